shifter_arbiter: RTL and testbench
==================================

// Module: shifter_arbiter
// PURPOSE
// - Shares one full_barrel_shifter between two requesters (port 0: core ALU
//   shift path, port 1: auxiliary unit such as CSR/crypto helper).
// - Per-port valid/ready request and response handshakes.
// - Round-robin grant, registered operands and registered result.
// - One operation in flight; a port holds its grant until its response is taken.
// PARAMETERS
// - XLEN     32  data width; must be a power of two >= 8
// - SHAMT_W  $clog2(XLEN)  shift-amount width (derived, not overridden)
// PORTS
// - clock          in   1          single clock; all state updates on rising edge
// - reset_n        in   1          reset, synchronous, active-low
// - req_valid      in   [1:0]      request present, per port
// - req_ready      out  [1:0]      request accepted this cycle, per port
// - req_data       in   [1:0][XLEN-1:0]     operand, per port
// - req_shamt      in   [1:0][SHAMT_W-1:0]  shift amount, per port
// - req_op         in   [1:0] shift_op_t    SLL/SRL/SRA, per port
// - resp_valid     out  [1:0]      result available, per port
// - resp_ready     in   [1:0]      result consumed, per port
// - resp_data      out  XLEN       shifted result; valid only where resp_valid=1
// - busy           out  1          state != IDLE
// BEHAVIOUR
// - FSM states:
//   - IDLE: req_ready asserted only for the port selected by the arbiter.
//     On req_valid[g] & req_ready[g], capture data/shamt/op/g, go to EXEC.
//   - EXEC: shifter driven from the captured registers; out_data goes into
//     result_q; next state RESP.
//   - RESP: resp_valid[g]=1, resp_data=result_q. On resp_ready[g], go to IDLE
//     and set last_grant<=g. Otherwise hold, with data stable.
// - Arbitration (combinational in IDLE):
//   - Only one port valid -> that port wins.
//   - Both valid -> the port != last_grant wins.
//   - None valid -> req_ready=0.
// - Latency: accept at cycle N -> resp_valid at cycle N+2. Back-to-back
//   throughput is one op per 3 cycles with resp_ready held at 1.
// - Op mapping onto the shifter:
//   - SLL: left shift, logical.
//   - SRL: right shift, logical.
//   - SRA: right shift, arithmetic (sign fill).
// - shamt=0 returns data unchanged for all ops. Only SHAMT_W bits are used.
// - req_ready is never asserted outside IDLE. A request on the non-granted
//   port is held by the requester; it is never dropped or reordered.
// - resp_valid only on the captured port; the other port reads 0.
//   resp_ready on a non-granted port is ignored.
// - A requester changing req_* while not ready: ignored, since capture happens
//   only at handshake.
// - Reset (reset_n=0 on a rising edge), also when taken mid-EXEC/RESP:
//   - state=IDLE; req_ready=0 during the reset cycle; resp_valid=0.
//   - result_q=0, resp_data=0, busy=0, last_grant=1 (port 0 wins the first tie).
//   - Any in-flight op is discarded.
// - Illegal op encoding: treated as SLL.
// STRUCTURE
// - Package shifter_pkg:
//   - typedef enum logic [1:0] shift_op_t {SLL=0, SRL=1, SRA=2}
//   - typedef enum logic [1:0] arb_state_t {IDLE, EXEC, RESP}
//   - Function op_to_ctrl() returning the shifter's left/right and arithmetic bits.
// - Sub-module: one full_barrel_shifter #(.XLEN(XLEN)) instance fed from the
//   operand registers.
// - Arbiter, FSM and registers are written inline; no other sub-modules.
// TESTING (XLEN=32; every response checked against a reference model)
// - Reset: reset_n=0 for 2 cycles with req_valid=2'b11 -> req_ready=0,
//   resp_valid=0, busy=0, resp_data=0.
// - Single op: port0 SLL data=0x0000_00F1, shamt=4 -> resp_valid[0] 2 cycles
//   after accept, resp_data=0x0000_0F10.
// - Sign fill: port1 SRA 0x8000_0000 >> 31 -> 0xFFFF_FFFF. Then SRL, same
//   operands -> 0x0000_0001.
// - Contention: req_valid=2'b11 held with resp_ready=2'b11.
//   - Grant order: 0, 1, 0, 1.
//   - Each port's results match its own operands; no starvation over 20 ops.
// - Backpressure: resp_ready[0]=0 for 5 cycles.
//   - resp_valid[0] and resp_data are held stable.
//   - req_ready=2'b00 throughout; the op completes when resp_ready rises.
// - Reset mid-EXEC and mid-RESP:
//   - Next cycle: IDLE, resp_valid=0.
//   - Following op (SLL 1 << 0) -> 0x0000_0001 with port0 first-tie priority.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the shifter arbiter: op encoding, FSM states, shifter control.
package shifter_pkg;

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic left;
    logic arith;
  } shift_ctrl_t;

  // Map an op onto shifter direction/fill controls; the unused encoding falls back to SLL.
  function automatic shift_ctrl_t op_to_ctrl(input shift_op_t op);
    shift_ctrl_t ctrl;
    ctrl.left  = 1'b1;
    ctrl.arith = 1'b0;
    case (op)
      SRL: ctrl.left = 1'b0;
      SRA: begin
        ctrl.left  = 1'b0;
        ctrl.arith = 1'b1;
      end
      default: ;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/full_barrel_shifter.sv
// Log-stage barrel shifter. Left shifts reuse the right-shift stages by
// bit-reversing the operand on the way in and the result on the way out.
module full_barrel_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic [XLEN-1:0]    in_data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               left,
  input  logic               arith,
  output logic [XLEN-1:0]    out_data
);

  logic [XLEN-1:0] src;
  logic [XLEN-1:0] stg [SHAMT_W+1];
  logic            fill;

  assign fill = arith & ~left & in_data[XLEN-1];

  // Reverse the operand for left shifts.
  always_comb begin
    src = '0;
    for (int b = 0; b < XLEN; b++) begin
      src[b] = left ? in_data[XLEN-1-b] : in_data[b];
    end
  end

  assign stg[0] = src;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    assign stg[i+1] = shamt[i] ? {{(2**i){fill}}, stg[i][XLEN-1:2**i]} : stg[i];
  end

  // Undo the reversal for left shifts.
  always_comb begin
    out_data = '0;
    for (int b = 0; b < XLEN; b++) begin
      out_data[b] = left ? stg[SHAMT_W][XLEN-1-b] : stg[SHAMT_W][b];
    end
  end

endmodule

// File: rtl/shifter_arbiter.sv
// Two-port round-robin front end sharing one barrel shifter, one op in flight.
//
//   state | meaning
//   IDLE  | arbiter offers req_ready to the winning port; capture on handshake
//   EXEC  | shifter runs on the captured operands; result registered
//   RESP  | resp_valid on the captured port until its resp_ready
module shifter_arbiter
  import shifter_pkg::*;
#(
  parameter  int XLEN    = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [1:0][XLEN-1:0]        req_data,
  input  logic [1:0][SHAMT_W-1:0]     req_shamt,
  input  shift_op_t [1:0]             req_op,
  output logic [1:0]                  resp_valid,
  input  logic [1:0]                  resp_ready,
  output logic [XLEN-1:0]             resp_data,
  output logic                        busy
);

  arb_state_t       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  shift_ctrl_t      ctrl_q, ctrl_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             arb_valid;
  logic             arb_sel;
  logic [XLEN-1:0]  shift_out;

  full_barrel_shifter #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shifter (
    .in_data  (data_q),
    .shamt    (shamt_q),
    .left     (ctrl_q.left),
    .arith    (ctrl_q.arith),
    .out_data (shift_out)
  );

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    arb_valid = |req_valid;
    arb_sel   = 1'b0;
    case (req_valid)
      2'b01:   arb_sel = 1'b0;
      2'b10:   arb_sel = 1'b1;
      2'b11:   arb_sel = ~last_grant_q;
      default: arb_sel = 1'b0;
    endcase
    req_ready = 2'b00;
    if (state_q == IDLE && reset_n && arb_valid) begin
      req_ready[arb_sel] = 1'b1;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    shamt_d      = shamt_q;
    ctrl_d       = ctrl_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (|req_ready) begin
          data_d  = req_data[arb_sel];
          shamt_d = req_shamt[arb_sel];
          ctrl_d  = op_to_ctrl(req_op[arb_sel]);
          grant_d = arb_sel;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = shift_out;
        state_d  = RESP;
      end
      RESP: begin
        if (resp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight op and favours port 0 on the first tie.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      shamt_q      <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      shamt_q      <= shamt_d;
      ctrl_q       <= ctrl_d;
      result_q     <= result_d;
    end
  end

  // Response outputs decoded from registered state only.
  always_comb begin
    resp_valid = 2'b00;
    if (state_q == RESP && reset_n) begin
      resp_valid[grant_q] = 1'b1;
    end
    resp_data = result_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter: directed cases, random ops, contention, resets.
module tb_shifter_arbiter;
  import shifter_pkg::*;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0][XLEN-1:0]    req_data;
  logic [1:0][SHAMT_W-1:0] req_shamt;
  shift_op_t [1:0]         req_op;
  logic [1:0]              resp_valid;
  logic [1:0]              resp_ready;
  logic [XLEN-1:0]         resp_data;
  logic                    busy;

  int n_checks = 0;
  int n_fail   = 0;
  int model_last = 1;
  int grant_cnt [2];

  shifter_arbiter #(.XLEN(XLEN)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_shamt  (req_shamt),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference shift by plain integer arithmetic (multiply / floor-divide by 2**s).
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input int op);
    longint p = 1;
    longint ud;
    longint sd;
    longint r;
    for (int k = 0; k < s; k++) p = p * 2;
    ud = d;
    sd = d[31] ? ud - 64'sh1_0000_0000 : ud;
    case (op)
      1:       r = ud / p;
      2:       r = (sd >= 0) ? sd / p : -((-sd + p - 1) / p);
      default: r = ud * p;
    endcase
    return r[31:0];
  endfunction

  function automatic int exp_grant(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return 1 - model_last;
  endfunction

  task automatic set_req(input int p, input logic [31:0] d, input int s, input int op);
    req_data[p]  = d;
    req_shamt[p] = s[4:0];
    req_op[p]    = shift_op_t'(op[1:0]);
    req_valid[p] = 1'b1;
  endtask

  // Wait (bounded) for the handshake, check the grant, and step into EXEC.
  task automatic accept(input int exp_p, input bit keep, output int got);
    int cyc = 0;
    got = -1;
    #1;
    while (req_ready == 2'b00 && cyc < 8) begin
      @(negedge clock);
      #1;
      cyc++;
    end
    if (req_ready == 2'b00) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready 0x%0h expected a grant", req_ready);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "no grant");
    end
    check_eq("grant", {30'b0, req_ready}, 32'(1 << exp_p));
    got = req_ready[1] ? 1 : 0;
    @(negedge clock);
    if (!keep) req_valid[got] = 1'b0;
    check_eq("exec_resp_valid", {30'b0, resp_valid}, 32'h0);
    check_eq("exec_busy", {31'b0, busy}, 32'h1);
    check_eq("exec_req_ready", {30'b0, req_ready}, 32'h0);
  endtask

  // Check the response two cycles after accept, optionally stall it, then retire it.
  task automatic response(input int p, input logic [31:0] exp, input int stall);
    @(negedge clock);
    check_eq("resp_valid", {30'b0, resp_valid}, 32'(1 << p));
    check_eq("resp_data", resp_data, exp);
    if (stall > 0) begin
      resp_ready[p]     = 1'b0;
      resp_ready[1 - p] = 1'b1;
      repeat (stall) begin
        @(negedge clock);
        check_eq("hold_valid", {30'b0, resp_valid}, 32'(1 << p));
        check_eq("hold_data", resp_data, exp);
        check_eq("hold_req_ready", {30'b0, req_ready}, 32'h0);
      end
      resp_ready = 2'b11;
    end
    @(negedge clock);
    check_eq("post_resp_valid", {30'b0, resp_valid}, 32'h0);
    model_last = p;
  endtask

  task automatic do_op_exp(input int p, input logic [31:0] d, input int s, input int op,
                           input int stall, input logic [31:0] exp);
    int got;
    set_req(p, d, s, op);
    accept(exp_grant(req_valid), 1'b0, got);
    response(got, exp, stall);
  endtask

  task automatic do_op(input int p, input logic [31:0] d, input int s, input int op, input int stall);
    do_op_exp(p, d, s, op, stall, ref_shift(d, s, op));
  endtask

  task automatic post_reset_checks(input string tag);
    #1;
    check_eq({tag, "_req_ready"}, {30'b0, req_ready}, 32'h0);
    check_eq({tag, "_resp_valid"}, {30'b0, resp_valid}, 32'h0);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'h0);
    check_eq({tag, "_resp_data"}, resp_data, 32'h0);
  endtask

  // Tie after reset: port 0 must win, then port 1 drains.
  task automatic tie_after_reset();
    int got;
    set_req(0, 32'h1, 0, 0);
    set_req(1, 32'h1, 0, 0);
    accept(0, 1'b0, got);
    response(got, 32'h0000_0001, 0);
    accept(1, 1'b0, got);
    response(got, 32'h0000_0001, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic [31:0] d, expv;
    int s, op, p;

    reset_n    = 1'b0;
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    req_data   = '0;
    req_shamt  = '0;
    req_op     = {SLL, SLL};
    repeat (2) @(negedge clock);
    post_reset_checks("reset");
    req_valid  = 2'b00;
    reset_n    = 1'b1;
    model_last = 1;
    @(negedge clock);

    // Directed cases
    do_op_exp(0, 32'h0000_00F1, 4, 0, 0, 32'h0000_0F10);
    do_op_exp(1, 32'h8000_0000, 31, 2, 0, 32'hFFFF_FFFF);
    do_op_exp(1, 32'h8000_0000, 31, 1, 0, 32'h0000_0001);
    do_op_exp(0, 32'hA5A5_1234, 0, 2, 0, 32'hA5A5_1234);
    do_op_exp(1, 32'hA5A5_1234, 0, 1, 0, 32'hA5A5_1234);
    do_op_exp(0, 32'h0000_0001, 3, 3, 0, 32'h0000_0008);
    do_op_exp(0, 32'h1234_5678, 8, 0, 5, 32'h3456_7800);
    do_op_exp(1, 32'h7000_0000, 4, 2, 2, 32'h0700_0000);

    // Random single-port ops with random stalls
    for (int k = 0; k < 30; k++) begin
      p  = int'($urandom_range(0, 1));
      d  = $urandom;
      s  = int'($urandom_range(0, 31));
      op = int'($urandom_range(0, 3));
      do_op(p, d, s, op, int'($urandom_range(0, 3)));
    end

    // Contention after reset: alternating grants starting at port 0
    reset_n = 1'b0;
    @(negedge clock);
    reset_n    = 1'b1;
    model_last = 1;
    grant_cnt[0] = 0;
    grant_cnt[1] = 0;
    set_req(0, $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    set_req(1, $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    for (int k = 0; k < 20; k++) begin
      accept(exp_grant(req_valid), 1'b1, got);
      expv = ref_shift(req_data[got], int'(req_shamt[got]), int'(req_op[got]));
      grant_cnt[got]++;
      set_req(got, $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
      response(got, expv, 0);
    end
    check_eq("port0_grants", grant_cnt[0], 32'd10);
    check_eq("port1_grants", grant_cnt[1], 32'd10);
    req_valid = 2'b00;
    @(negedge clock);

    // Reset taken in EXEC
    set_req(1, 32'hDEAD_BEEF, 4, 1);
    accept(1, 1'b0, got);
    reset_n = 1'b0;
    req_valid = 2'b11;
    @(negedge clock);
    post_reset_checks("rst_exec");
    req_valid  = 2'b00;
    reset_n    = 1'b1;
    model_last = 1;
    tie_after_reset();

    // Reset taken in RESP
    set_req(1, 32'hCAFE_0001, 1, 0);
    accept(1, 1'b0, got);
    resp_ready = 2'b00;
    @(negedge clock);
    check_eq("rst_resp_pre_valid", {30'b0, resp_valid}, 32'h2);
    check_eq("rst_resp_pre_data", resp_data, 32'h95FC_0002);
    reset_n = 1'b0;
    @(negedge clock);
    post_reset_checks("rst_resp");
    resp_ready = 2'b11;
    reset_n    = 1'b1;
    model_last = 1;
    tie_after_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
